// File: rtl/bmult_share_pkg.sv
// Shared types and widths for the shared 16x16 multiplier arbiter.
package bmult_share_pkg;

  localparam int OP_W      = 16;
  localparam int P_W       = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDX_W = 3;
  localparam int CNT_W     = 16;

  // Tracks one in-flight multiply: who asked for it and whether the slot is live.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bmult_rr_arb.sv
// Round-robin picker: first valid index at or after ptr, wrapping.
// Produces a one-hot grant, the granted index, and an any-grant flag.
module bmult_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan N positions starting at ptr; the first valid one wins.
  always_comb begin
    int s;
    logic [IDX_W-1:0] idx_c;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    s       = 0;
    idx_c   = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      idx_c = IDX_W'(s);
      if (!any && valid[idx_c]) begin
        any          = 1'b1;
        gnt[idx_c]   = 1'b1;
        gnt_idx      = idx_c;
      end
    end
  end

endmodule

// File: rtl/bmult_share_arb.sv
// bmult_share_arb: shares one pipelined 16x16 multiplier among NUM_REQ
// requesters with round-robin issue, full throughput and no response
// backpressure. Each grant carries a tag down a pipe matched to the
// multiplier latency so the product can be steered back to its owner.
// Optional: define BMULT_SHARE_ARB_STATS_EN to add per-requester
// saturating grant counters on port grant_cnt.
module bmult_share_arb
  import bmult_share_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [P_W-1:0]                resp_p,
  output logic [OP_W-1:0]               mult_a,
  output logic [OP_W-1:0]               mult_b,
  input  logic [P_W-1:0]                mult_p,
  output logic                          idle
`ifdef BMULT_SHARE_ARB_STATS_EN
  ,output logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  // Tag stage s is live during the cycle s+1 after the grant edge; the
  // last stage lines up with the product leaving the multiplier.
  localparam int STAGES = MULT_LAT;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  tag_t               tag_in;
  tag_t               tag_pipe [STAGES:0];

  // Nothing is offered while disabled or held in reset.
  assign arb_valid = (en && !rst) ? req_valid : '0;

  bmult_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .valid   (arb_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign req_ready = gnt;
  assign resp_p    = mult_p;

  // Build the tag for this cycle's grant (idx widened to the package width).
  always_comb begin
    tag_in              = '0;
    tag_in.valid        = gnt_any;
    tag_in.idx[IDX_W-1:0] = gnt_idx;
  end

  // Operand capture and pointer advance on every grant; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      mult_a <= '0;
      mult_b <= '0;
    end else if (gnt_any) begin
      mult_a <= req_a[gnt_idx];
      mult_b <= req_b[gnt_idx];
      ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag shift pipe; reset drops every in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= STAGES; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Steer the completing tag to a one-cycle response strobe.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = tag_pipe[STAGES].valid &&
                      (tag_pipe[STAGES].idx == TAG_IDX_W'(i));
  end

  // Idle when no stage holds a live tag.
  always_comb begin
    idle = 1'b1;
    for (int s = 0; s <= STAGES; s++)
      if (tag_pipe[s].valid) idle = 1'b0;
  end

`ifdef BMULT_SHARE_ARB_STATS_EN
  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
    end
  end
`endif

endmodule

// File: tb/tb_bmult_share_arb.sv
// Directed bench for bmult_share_arb with a behavioural Bmult16x16
// (MULT_LAT register stages from mult_a/mult_b to mult_p).
module tb_bmult_share_arb;

  localparam int NR  = 4;
  localparam int LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][15:0]  req_a;
  logic [NR-1:0][15:0]  req_b;
  logic [NR-1:0]        resp_valid;
  logic [31:0]          resp_p;
  logic [15:0]          mult_a;
  logic [15:0]          mult_b;
  logic [31:0]          mult_p;
  logic                 idle;
`ifdef BMULT_SHARE_ARB_STATS_EN
  logic [NR-1:0][15:0]  grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bmult_share_arb #(.NUM_REQ(NR), .MULT_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_p     (resp_p),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .idle       (idle)
`ifdef BMULT_SHARE_ARB_STATS_EN
    ,.grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: product appears LAT edges after operands are presented.
  logic [31:0] mpipe [LAT-1:0];
  always_ff @(posedge clk) begin
    mpipe[0] <= 32'(mult_a) * 32'(mult_b);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mult_p = mpipe[LAT-1];

  // Hand-computed products for operand set a[i]=i+1, b[i]=16+i.
  logic [31:0] prod_tbl [NR];
  initial begin
    prod_tbl[0] = 32'd16;   // 1*16
    prod_tbl[1] = 32'd34;   // 2*17
    prod_tbl[2] = 32'd54;   // 3*18
    prod_tbl[3] = 32'd76;   // 4*19
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_std_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i] = 16'(i + 1);
      req_b[i] = 16'(16 + i);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '1;
    set_std_ops();

    // ---- reset state ----
    tick(); #1;
    chk("rst_ready",  32'(req_ready),  32'h0);
    chk("rst_resp",   32'(resp_valid), 32'h0);
    chk("rst_idle",   32'(idle),       32'h1);
    chk("rst_mult_a", 32'(mult_a),     32'h0);
    chk("rst_mult_b", 32'(mult_b),     32'h0);
    req_valid = '0;
    rst = 1'b0;

    // ---- single request: req 2, 3*5 ----
    tick();
    req_a[2] = 16'h0003; req_b[2] = 16'h0005; req_valid = 4'b0100; #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_idle0", 32'(idle),      32'h1);
    tick();
    req_valid = '0; #1;
    chk("single_mult_a", 32'(mult_a),    32'h3);
    chk("single_mult_b", 32'(mult_b),    32'h5);
    chk("single_busy",   32'(idle),      32'h0);
    chk("single_resp1",  32'(resp_valid), 32'h0);
    tick(); #1;
    chk("single_resp2",  32'(resp_valid), 32'h0);
    tick(); #1;
    chk("single_resp3",  32'(resp_valid), 32'h4);
    chk("single_p",      resp_p,          32'h0000000F);
    tick(); #1;
    chk("single_resp4",  32'(resp_valid), 32'h0);
    chk("single_idle1",  32'(idle),       32'h1);

    // Async reset pulse mid-cycle returns ptr to 0.
    rst = 1'b1; #1; rst = 1'b0;

    // ---- all four valid for 8 cycles ----
    set_std_ops();
    for (int k = 0; k < 11; k++) begin
      tick();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000; #1;
      if (k < 8)
        chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 3) begin
        chk($sformatf("rr_resp_%0d", k), 32'(resp_valid), 32'(1 << ((k - 3) % 4)));
        chk($sformatf("rr_p_%0d", k), resp_p, prod_tbl[(k - 3) % 4]);
      end
    end
    tick(); #1;
    chk("rr_idle", 32'(idle), 32'h1);

    // ---- extremes (ptr back at 0) ----
    req_a[0] = 16'hFFFF; req_b[0] = 16'hFFFF;
    req_a[1] = 16'h0000; req_b[1] = 16'hFFFF;
    req_valid = 4'b0001; #1;
    chk("ext_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010; #1;
    chk("ext_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick(); #1;
    chk("ext_resp0", 32'(resp_valid), 32'h1);
    chk("ext_p0",    resp_p,          32'hFFFE0001);
    tick(); #1;
    chk("ext_resp1", 32'(resp_valid), 32'h2);
    chk("ext_p1",    resp_p,          32'h00000000);

    // ---- en drop with 3 in flight (ptr = 2: grants 2,3,0) ----
    set_std_ops();
    for (int k = 0; k < 7; k++) begin
      tick();
      req_valid = 4'b1111;
      en = (k < 3); #1;
      case (k)
        0: chk("en_ready0", 32'(req_ready), 32'h4);
        1: chk("en_ready1", 32'(req_ready), 32'h8);
        2: chk("en_ready2", 32'(req_ready), 32'h1);
        default: chk($sformatf("en_noready_%0d", k), 32'(req_ready), 32'h0);
      endcase
      case (k)
        3: begin chk("en_resp3", 32'(resp_valid), 32'h4); chk("en_p3", resp_p, 32'd54); end
        4: begin chk("en_resp4", 32'(resp_valid), 32'h8); chk("en_p4", resp_p, 32'd76); end
        5: begin chk("en_resp5", 32'(resp_valid), 32'h1); chk("en_p5", resp_p, 32'd16);
                 chk("en_busy5", 32'(idle), 32'h0); end
        6: begin chk("en_resp6", 32'(resp_valid), 32'h0); chk("en_idle6", 32'(idle), 32'h1); end
        default: ;
      endcase
    end

    // ---- reset with 2 in flight (ptr = 1: grants 1,2) ----
    req_valid = '0; en = 1'b1;
    tick();
    req_valid = 4'b1111; #1;
    chk("rstf_ready0", 32'(req_ready), 32'h2);
    tick(); #1;
    chk("rstf_ready1", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst = 1'b1; #1;
    chk("rstf_idle",   32'(idle),       32'h1);
    chk("rstf_resp",   32'(resp_valid), 32'h0);
    chk("rstf_mult_a", 32'(mult_a),     32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk($sformatf("rstf_noresp_%0d", k), 32'(resp_valid), 32'h0);
    end
    req_valid = 4'b1111; #1;
    chk("rstf_ptr0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;

`ifdef BMULT_SHARE_ARB_STATS_EN
    // ---- saturating counters: 70000 grants to req 1 ----
    rst = 1'b1; #1; rst = 1'b0;
    chk("cnt_clear", 32'(grant_cnt[1]), 32'h0);
    req_valid = 4'b0010;
    for (int k = 0; k < 70000; k++) tick();
    req_valid = '0; #1;
    chk("cnt_sat1", 32'(grant_cnt[1]), 32'hFFFF);
    chk("cnt_0",    32'(grant_cnt[0]), 32'h0);
    chk("cnt_2",    32'(grant_cnt[2]), 32'h0);
    chk("cnt_3",    32'(grant_cnt[3]), 32'h0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
